lane_track_filter: RTL and testbench

//  Downstream stage of the lane-detect controller. Consumes one per-frame lane result:

---
 rtl/lane_track_filter.sv | 136 +++++++++++++
 tb/tb_lane_track_filter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lane_track_filter.sv
// Lane result filter: confidence-gated EMA plus lost-lane tracking, emitting a framed byte packet.
// Define LANE_PKT_CHECKSUM_EN to append an XOR checksum byte (5-byte packets instead of 4).
module lane_track_filter #(
    parameter int         CONF_MIN       = 32,
    parameter int         ALPHA_SHIFT    = 2,
    parameter int         FRAC_BITS      = 4,
    parameter int         LOST_FRAMES    = 8,
    parameter int         CENTER_DEFAULT = 15,
    parameter logic [7:0] HEADER         = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_center,
    input  logic [7:0] in_confidence,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       lost
);
`ifdef LANE_PKT_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int AW = 8 + FRAC_BITS;
    localparam int IW = $clog2(NB);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] UPDATE = 2'd1;
    localparam logic [1:0] SEND   = 2'd2;
    localparam logic [AW-1:0] ACC_DEFAULT = AW'(CENTER_DEFAULT << FRAC_BITS);
    localparam logic [AW:0]   ROUND       = (AW+1)'(1 << (FRAC_BITS - 1));

    logic [1:0]          state;
    logic [7:0]          lat_center, lat_conf;
    logic [7:0]          miss_cnt, miss_nxt;
    logic [AW-1:0]       acc, acc_nxt;
    logic                lost_nxt, overrun;
    logic [IW-1:0]       idx;
    logic [NB-1:0][7:0]  pkt, pkt_nxt;

    logic signed [AW:0]  diff, ema;
    logic [AW:0]         rounded;
    logic [8:0]          miss_inc;
    logic [AW-FRAC_BITS:0] filt_w;
    logic [7:0]          filtered;
    logic [4:0]          miss5;

    assign busy = (state != IDLE);

    // Next filter state and packet contents, evaluated while in UPDATE.
    always_comb begin
        diff     = $signed({1'b0, lat_center, {FRAC_BITS{1'b0}}}) - $signed({1'b0, acc});
        ema      = $signed({1'b0, acc}) + (diff >>> ALPHA_SHIFT);
        miss_inc = {1'b0, miss_cnt} + 9'd1;
        acc_nxt  = acc;
        lost_nxt = lost;
        miss_nxt = miss_cnt;
        if (lat_conf >= 8'(CONF_MIN)) begin
            if (lost) begin
                acc_nxt  = {lat_center, {FRAC_BITS{1'b0}}};
                lost_nxt = 1'b0;
                miss_nxt = 8'd0;
            end else begin
                acc_nxt = ema[AW-1:0];
            end
        end else begin
            miss_nxt = miss_inc[8] ? 8'hFF : miss_inc[7:0];
            if (miss_inc >= 9'(LOST_FRAMES)) begin
                lost_nxt = 1'b1;
                acc_nxt  = ACC_DEFAULT;
            end
        end
        rounded    = {1'b0, acc_nxt} + ROUND;
        filt_w     = rounded[AW:FRAC_BITS];
        filtered   = filt_w[8] ? 8'hFF : filt_w[7:0];
        miss5      = (miss_nxt > 8'd31) ? 5'd31 : miss_nxt[4:0];
        pkt_nxt[0] = HEADER;
        pkt_nxt[1] = filtered;
        pkt_nxt[2] = lat_conf;
        pkt_nxt[3] = {lost_nxt, overrun, 1'b0, miss5};
`ifdef LANE_PKT_CHECKSUM_EN
        pkt_nxt[4] = HEADER ^ filtered ^ lat_conf ^ {lost_nxt, overrun, 1'b0, miss5};
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx_valid   <= 1'b0;
            tx_byte    <= 8'd0;
            lost       <= 1'b0;
            miss_cnt   <= 8'd0;
            overrun    <= 1'b0;
            acc        <= ACC_DEFAULT;
            idx        <= '0;
            lat_center <= 8'd0;
            lat_conf   <= 8'd0;
            pkt        <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    lat_center <= in_center;
                    lat_conf   <= in_confidence;
                    state      <= UPDATE;
                end
                UPDATE: begin
                    acc      <= acc_nxt;
                    lost     <= lost_nxt;
                    miss_cnt <= miss_nxt;
                    pkt      <= pkt_nxt;
                    overrun  <= 1'b0;
                    tx_byte  <= HEADER;
                    tx_valid <= 1'b1;
                    idx      <= '0;
                    state    <= SEND;
                end
                SEND: if (tx_valid && tx_ready) begin
                    if (idx == IW'(NB - 1)) begin
                        tx_valid <= 1'b0;
                        tx_byte  <= 8'd0;
                        state    <= IDLE;
                    end else begin
                        idx     <= idx + IW'(1);
                        tx_byte <= pkt[idx + IW'(1)];
                    end
                end
                default: state <= IDLE;
            endcase
            // A frame arriving while busy is dropped; this set wins over the UPDATE clear.
            if (in_valid && state != IDLE)
                overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lane_track_filter.sv
// Scoreboard bench for lane_track_filter: a reference model pushes expected packet bytes,
// a monitor pops and compares on every accepted byte.
module tb_lane_track_filter;
    logic       clk = 1'b0;
    logic       rst, in_valid, tx_valid, tx_ready, busy, lost;
    logic [7:0] in_center, in_confidence, tx_byte;

    int         checks = 0, failures = 0, accepts = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_b, last_byte;
    int         m_acc, m_lost, m_miss, m_ovr;

    always #5 clk = ~clk;

    lane_track_filter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_center(in_center),
        .in_confidence(in_confidence), .tx_byte(tx_byte), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .lost(lost)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_byte", {24'd0, tx_byte}, 32'h100);
            end else begin
                exp_b = sb.pop_front();
                chk("byte", {24'd0, tx_byte}, {24'd0, exp_b});
            end
            last_byte = tx_byte;
            accepts++;
        end
    end

    task automatic model_reset();
        m_acc = 15 * 16; m_lost = 0; m_miss = 0; m_ovr = 0;
    endtask

    task automatic push_model(input int c, input int conf);
        int filt, mm;
        logic [7:0] b1, b2, b3;
        if (conf >= 32) begin
            if (m_lost != 0) begin
                m_acc = c * 16; m_lost = 0; m_miss = 0;
            end else begin
                m_acc = m_acc + ((c * 16 - m_acc) >>> 2);
            end
        end else begin
            m_miss = (m_miss < 255) ? m_miss + 1 : 255;
            if (m_miss >= 8) begin
                m_lost = 1; m_acc = 15 * 16;
            end
        end
        filt = (m_acc + 8) >> 4;
        if (filt > 255) filt = 255;
        mm = (m_miss > 31) ? 31 : m_miss;
        b1 = filt[7:0];
        b2 = conf[7:0];
        b3 = {m_lost[0], m_ovr[0], 1'b0, mm[4:0]};
        m_ovr = 0;
        sb.push_back(8'hA5); sb.push_back(b1); sb.push_back(b2); sb.push_back(b3);
`ifdef LANE_PKT_CHECKSUM_EN
        sb.push_back(8'hA5 ^ b1 ^ b2 ^ b3);
`endif
    endtask

    task automatic frame(input int c, input int conf);
        @(posedge clk); #1;
        in_valid = 1'b1; in_center = c[7:0]; in_confidence = conf[7:0];
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || sb.size() != 0) && n < 300) begin
            @(negedge clk); n++;
        end
        if (n >= 300) chk("timeout_idle", n, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int n, base;
        rst = 1'b1; in_valid = 1'b0; in_center = 8'd0; in_confidence = 8'd0; tx_ready = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lost", lost, 0);
        @(posedge clk); #1 rst = 1'b0;

        // basic frame with latency checks
        push_model(23, 100);
        frame(23, 100);
        @(negedge clk);
        chk("lat_update_valid", tx_valid, 0);
        chk("lat_update_busy", busy, 1);
        @(negedge clk);
        chk("lat_b0_valid", tx_valid, 1);
        chk("lat_b0_byte", tx_byte, 8'hA5);
        wait_idle();
        chk("t1_last_b3", last_byte, 8'h00);
        chk("t1_lost", lost, 0);

        // eight low-confidence frames drive the lane lost
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push_model(20, 10);
            frame(20, 10);
            wait_idle();
            chk("t2_lost", lost, (i == 7) ? 1 : 0);
        end
        chk("t2_last_b3", last_byte, 8'h88);

        // reacquire snaps to the measurement
        push_model(5, 200);
        frame(5, 200);
        wait_idle();
        chk("t3_lost", lost, 0);
        chk("t3_last_b3", last_byte, 8'h00);

        // backpressure holds B0, overlapping frame is dropped and flagged
        tx_ready = 1'b0;
        push_model(12, 90);
        frame(12, 90);
        n = 0;
        while (!tx_valid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("t4_timeout_valid", n, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_byte", tx_byte, 8'hA5);
            chk("t4_hold_valid", tx_valid, 1);
        end
        frame(29, 250);
        m_ovr = 1;
        tx_ready = 1'b1;
        wait_idle();
        push_model(12, 90);
        frame(12, 90);
        wait_idle();
        chk("t4_ovr_set", last_byte[6], 1);
        push_model(12, 90);
        frame(12, 90);
        wait_idle();
        chk("t4_ovr_clear", last_byte[6], 0);

        // reset after two accepted bytes abandons the packet
        base = accepts;
        push_model(23, 100);
        frame(23, 100);
        n = 0;
        while (accepts < base + 2 && n < 50) begin @(posedge clk); n++; end
        if (n >= 50) chk("t5_timeout_accept", n, 0);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_valid", tx_valid, 0);
        chk("t5_rst_busy", busy, 0);
        sb.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push_model(23, 100);
        frame(23, 100);
        wait_idle();
        chk("t5_after_b3", last_byte, 8'h00);
        chk("t5_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
